// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : Shared types and constants for the fetch/data memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DFLT       = 32'hDEAD_BEEF;
  localparam logic [31:0] MEM_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module  : mem_port_arbiter_if
// Brief   : Fetch, data and memory-bus signals of the memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        stall;
  logic        bus_err;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, stall, bus_err
  );

  // Pipeline stages and memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, stall, bus_err
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Arbitrates fetch and data requests onto one memory bus with
//           alternating fairness and back-to-back grants.
//           Optional bus timeout enabled by defining MEM_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DFLT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t  state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        i_ack_q;
  logic        d_ack_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        last_d_q;

  logic        w_timeout;
  logic [31:0] w_rdata;
  logic        w_pend_i;
  logic        w_pend_d;
  logic        w_done;
  logic        w_decide;
  logic        w_grant_i;
  logic        w_grant_d;

  // The current owner still holds its req, and a requester being acked this
  // cycle still shows its old req; neither may win a new grant.
  assign w_pend_i  = bus.i_req & ~i_ack_q & (state_q != I_BUSY);
  assign w_pend_d  = bus.d_req & ~d_ack_q & (state_q != D_BUSY);
  assign w_done    = (state_q != IDLE) & (bus.mem_ack | w_timeout);
  assign w_decide  = (state_q == IDLE) | w_done;
  assign w_grant_d = w_decide & w_pend_d & (~w_pend_i | ~last_d_q);
  assign w_grant_i = w_decide & w_pend_i & ~w_grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      last_d_q    <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;

      if (w_done) begin
        if (state_q == I_BUSY) begin
          i_ack_q   <= 1'b1;
          i_rdata_q <= w_rdata;
        end else begin
          d_ack_q <= 1'b1;
          if (!mem_we_q) begin
            d_rdata_q <= w_rdata;
          end
        end
        mem_req_q <= 1'b0;
        state_q   <= IDLE;
      end

      // A grant on the completion cycle overrides the drop to IDLE above.
      if (w_grant_d) begin
        state_q     <= D_BUSY;
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.d_we;
        mem_addr_q  <= bus.d_addr & MEM_ADDR_ALIGN_MASK;
        mem_wdata_q <= bus.d_wdata;
        last_d_q    <= 1'b1;
      end else if (w_grant_i) begin
        state_q    <= I_BUSY;
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= bus.i_addr & MEM_ADDR_ALIGN_MASK;
        last_d_q   <= 1'b0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned c_WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

  logic [c_WAIT_W-1:0] wait_cnt_q;
  logic                bus_err_q;

  // A mem_ack landing on the last allowed cycle completes normally.
  assign w_timeout = ~bus.mem_ack & (wait_cnt_q == c_WAIT_LAST);
  assign w_rdata   = bus.mem_ack ? bus.mem_rdata : ERR_DATA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= (state_q != IDLE) & w_timeout;
      if (w_grant_d | w_grant_i) begin
        wait_cnt_q <= '0;
      end else if ((state_q != IDLE) & ~bus.mem_ack) begin
        wait_cnt_q <= wait_cnt_q + c_WAIT_W'(1);
      end
    end
  end

  assign bus.bus_err = bus_err_q;
`else
  logic w_unused_params;

  assign w_timeout       = 1'b0;
  assign w_rdata         = bus.mem_rdata;
  assign bus.bus_err     = 1'b0;
  assign w_unused_params = ^{ERR_DATA, 32'(MAX_WAIT)};
`endif

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall     = bus.d_req & ~d_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter.
//           Timeout checks follow MEM_ARB_TIMEOUT_EN when it is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: acks after mem_ws wait states unless mem_dead is set.
  int   mem_ws    = 0;
  int   mem_cnt   = 0;
  bit   mem_dead  = 1'b0;
  bit   mem_force = 1'b0;

  mem_port_arbiter_if bif ();

  mem_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  assign bif.mem_ack = mem_force |
                       (bif.mem_req & ~mem_dead & (mem_cnt == mem_ws));

  always @(posedge clk) begin
    if (!bif.mem_req || bif.mem_ack) mem_cnt <= 0;
    else                             mem_cnt <= mem_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    bif.i_req     = 1'b0;
    bif.i_addr    = '0;
    bif.d_req     = 1'b0;
    bif.d_we      = 1'b0;
    bif.d_addr    = '0;
    bif.d_wdata   = '0;
    bif.mem_rdata = '0;
    #1 rst = 1'b0;

    // Reset state
    neg(); neg();
    chk("rst_mem_req", 32'(bif.mem_req), 32'd0);
    chk("rst_mem_we",  32'(bif.mem_we),  32'd0);
    chk("rst_i_ack",   32'(bif.i_ack),   32'd0);
    chk("rst_d_ack",   32'(bif.d_ack),   32'd0);
    chk("rst_mem_addr", bif.mem_addr,    32'h0);
    chk("rst_i_rdata",  bif.i_rdata,     32'h0);
    chk("rst_bus_err", 32'(bif.bus_err), 32'd0);
    chk("rst_stall",   32'(bif.stall),   32'd0);
    cyc();
    rst = 1'b1;

    // Single fetch, zero wait states
    cyc();
    bif.i_req = 1'b1; bif.i_addr = 32'h100; mem_ws = 0; bif.mem_rdata = 32'h6000_0000;
    neg(); chk("t1_req_t0", 32'(bif.mem_req), 32'd0);
    cyc(); neg();
    chk("t1_req_t1", 32'(bif.mem_req), 32'd1);
    chk("t1_addr",   bif.mem_addr,     32'h100);
    chk("t1_we",     32'(bif.mem_we),  32'd0);
    chk("t1_iack_t1", 32'(bif.i_ack),  32'd0);
    cyc(); neg();
    chk("t1_iack_t2", 32'(bif.i_ack),  32'd1);
    chk("t1_irdata",  bif.i_rdata,     32'h6000_0000);
    chk("t1_req_t2",  32'(bif.mem_req), 32'd0);
    cyc();
    bif.i_req = 1'b0;
    neg();
    chk("t1_iack_t3", 32'(bif.i_ack),   32'd0);
    chk("t1_req_t3",  32'(bif.mem_req), 32'd0);

    // Simultaneous requests out of reset: D first, then I back-to-back
    cyc(); rst = 1'b0;
    cyc(); rst = 1'b1;
    cyc();
    bif.i_req = 1'b1; bif.i_addr = 32'h180;
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h204;
    bif.mem_rdata = 32'h1111_2222;
    neg(); chk("t2_stall_c0", 32'(bif.stall), 32'd1);
    cyc(); neg();
    chk("t2_req_c1",  32'(bif.mem_req), 32'd1);
    chk("t2_addr_c1", bif.mem_addr,     32'h204);
    chk("t2_we_c1",   32'(bif.mem_we),  32'd0);
    chk("t2_stall_c1", 32'(bif.stall),  32'd1);
    cyc();
    bif.mem_rdata = 32'h3333_4444;
    neg();
    chk("t2_dack_c2",  32'(bif.d_ack),   32'd1);
    chk("t2_drdata",   bif.d_rdata,      32'h1111_2222);
    chk("t2_req_c2",   32'(bif.mem_req), 32'd1);
    chk("t2_addr_c2",  bif.mem_addr,     32'h180);
    chk("t2_stall_c2", 32'(bif.stall),   32'd0);
    cyc();
    bif.d_req = 1'b0;
    neg();
    chk("t2_iack_c3", 32'(bif.i_ack),   32'd1);
    chk("t2_irdata",  bif.i_rdata,      32'h3333_4444);
    chk("t2_req_c3",  32'(bif.mem_req), 32'd0);
    chk("t2_dack_c3", 32'(bif.d_ack),   32'd0);
    cyc();
    bif.i_req = 1'b0;

    // Store with three wait states
    cyc();
    bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_addr = 32'h303; bif.d_wdata = 32'hCAFE_F00D;
    mem_ws = 3; bif.mem_rdata = 32'h5555_AAAA;
    neg(); chk("t3_stall_s0", 32'(bif.stall), 32'd1);
    for (int s = 1; s <= 4; s++) begin
      cyc(); neg();
      chk("t3_req",   32'(bif.mem_req), 32'd1);
      chk("t3_addr",  bif.mem_addr,     32'h300);
      chk("t3_we",    32'(bif.mem_we),  32'd1);
      chk("t3_wdata", bif.mem_wdata,    32'hCAFE_F00D);
      chk("t3_dack",  32'(bif.d_ack),   32'd0);
    end
    cyc(); neg();
    chk("t3_dack_s5", 32'(bif.d_ack),   32'd1);
    chk("t3_req_s5",  32'(bif.mem_req), 32'd0);
    chk("t3_drdata",  bif.d_rdata,      32'h1111_2222);
    cyc();
    bif.d_req = 1'b0; bif.d_we = 1'b0;

    // Fairness: last grant was D, so I wins first, then strict alternation
    cyc();
    mem_ws = 0; bif.mem_rdata = 32'h0BAD_F00D;
    bif.i_req = 1'b1; bif.i_addr = 32'h400;
    bif.d_req = 1'b1; bif.d_addr = 32'h800;
    begin
      logic        exp_req  [6];
      logic [31:0] exp_addr [6];
      logic        exp_iack [6];
      logic        exp_dack [6];
      exp_req  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      exp_addr = '{32'h400, 32'h800, 32'h0, 32'h400, 32'h800, 32'h0};
      exp_iack = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_dack = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 6; k++) begin
        cyc();
        if (k == 5) begin
          bif.i_req = 1'b0; bif.d_req = 1'b0;
        end
        neg();
        chk("t4_req",  32'(bif.mem_req), 32'(exp_req[k]));
        if (exp_req[k]) chk("t4_addr", bif.mem_addr, exp_addr[k]);
        chk("t4_iack", 32'(bif.i_ack), 32'(exp_iack[k]));
        chk("t4_dack", 32'(bif.d_ack), 32'(exp_dack[k]));
      end
    end
    cyc(); neg();
    chk("t4_req_end", 32'(bif.mem_req), 32'd0);

    // Asynchronous reset in the middle of a data access
    cyc();
    mem_dead = 1'b1;
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h500;
    cyc(); neg();
    chk("t5_req_busy", 32'(bif.mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_req_rst",    32'(bif.mem_req), 32'd0);
    chk("t5_dack_rst",   32'(bif.d_ack),   32'd0);
    chk("t5_addr_rst",   bif.mem_addr,     32'h0);
    chk("t5_drdata_rst", bif.d_rdata,      32'h0);
    cyc();
    bif.d_req = 1'b0;
    cyc();
    rst = 1'b1; mem_dead = 1'b0;
    cyc();
    mem_force = 1'b1;
    neg(); chk("t5_req_idle", 32'(bif.mem_req), 32'd0);
    cyc();
    mem_force = 1'b0;
    neg();
    chk("t5_dack_stray",   32'(bif.d_ack), 32'd0);
    chk("t5_iack_stray",   32'(bif.i_ack), 32'd0);
    chk("t5_drdata_stray", bif.d_rdata,    32'h0);
    cyc();
    bif.d_req = 1'b1; bif.mem_rdata = 32'h7777_0001;
    cyc(); neg();
    chk("t5_req_reissue",  32'(bif.mem_req), 32'd1);
    chk("t5_addr_reissue", bif.mem_addr,     32'h500);
    cyc(); neg();
    chk("t5_dack_reissue", 32'(bif.d_ack),   32'd1);
    chk("t5_drdata_reiss", bif.d_rdata,      32'h7777_0001);
    cyc();
    bif.d_req = 1'b0;

    // Fetch that the memory never acknowledges
    cyc();
    mem_dead = 1'b1;
    bif.i_req = 1'b1; bif.i_addr = 32'h600;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int w = 1; w <= 4; w++) begin
      cyc(); neg();
      chk("t6_req_wait",  32'(bif.mem_req), 32'd1);
      chk("t6_berr_wait", 32'(bif.bus_err), 32'd0);
      chk("t6_iack_wait", 32'(bif.i_ack),   32'd0);
    end
    cyc(); neg();
    chk("t6_req_to",    32'(bif.mem_req), 32'd0);
    chk("t6_iack_to",   32'(bif.i_ack),   32'd1);
    chk("t6_irdata_to", bif.i_rdata,      32'hDEAD_BEEF);
    chk("t6_berr_to",   32'(bif.bus_err), 32'd1);
    cyc();
    bif.i_req = 1'b0;
    neg();
    chk("t6_berr_after", 32'(bif.bus_err), 32'd0);
    chk("t6_req_after",  32'(bif.mem_req), 32'd0);
`else
    for (int w = 1; w <= 8; w++) begin
      cyc(); neg();
      chk("t6_req_hold",  32'(bif.mem_req), 32'd1);
      chk("t6_berr_hold", 32'(bif.bus_err), 32'd0);
      chk("t6_iack_hold", 32'(bif.i_ack),   32'd0);
    end
    cyc();
    rst = 1'b0; bif.i_req = 1'b0;
    cyc();
    rst = 1'b1;
    neg();
    chk("t6_req_cleared", 32'(bif.mem_req), 32'd0);
`endif
    mem_dead = 1'b0;

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between the fetch stage (instruction reads) and the mem-access stage (LD/LDR reads, ST writes).
- Registers each granted request and drives the external bus until the memory acknowledges.
- Returns the read data and a one-cycle ack to the winning requester.
- Exports a pipeline stall while a data access is outstanding. Sits between the pipeline stages and the memory.

Parameters:
- MAX_WAIT, 64: cycles a bus transaction may wait for mem_ack before timeout (used only with the optional feature).
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timed-out access (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch read request; held until i_ack
- i_addr  in  32  fetch address
- i_ack  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  32  fetched instruction
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse: access complete, d_rdata valid for loads
- d_rdata  out  32  load data
- mem_req  out  1  bus request; held until mem_ack
- mem_we  out  1  bus write enable
- mem_addr  out  32  bus address, bits [1:0] forced to 00
- mem_wdata  out  32  bus write data
- mem_rdata  in  32  bus read data, valid with mem_ack
- mem_ack  in  1  bus completion, sampled only while mem_req=1
- stall  out  1  = d_req & ~d_ack (combinational); freezes the pipeline
- bus_err  out  1  one-cycle timeout pulse (optional feature; else tied 0)

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - mem_req, mem_we, i_ack, d_ack, bus_err = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - last_d = 0.
  - An in-flight transaction is abandoned with no ack. Requesters re-issue after reset.
- States: IDLE, I_BUSY, D_BUSY.
- Grant decision, made in IDLE or in a busy state on the mem_ack cycle:
  - Only d_req pending: grant D.
  - Only i_req pending: grant I.
  - Both pending: grant D if last_d=0, else grant I. This gives alternating fairness after each data access.
  - A requester whose ack pulses this cycle is not pending.
- On grant:
  - Latch addr (with [1:0]=00), wdata and we; mem_we=0 for I.
  - Set mem_req=1 the next cycle. Go to I_BUSY or D_BUSY.
  - Set last_d = 1 for a D grant, 0 for an I grant.
- Busy state, mem_ack=1:
  - Next cycle: pulse i_ack or d_ack, load i_rdata or d_rdata from mem_rdata (d_rdata unchanged on stores).
  - Drop mem_req, or re-assert it with a new grant (back-to-back). mem_req may stay high across the boundary with new address/we.
  - Otherwise return to IDLE.
- Busy state, mem_ack=0: hold all bus outputs stable.
- Latency: req to ack is 2 cycles minimum (memory acks in the first mem_req cycle). Add one cycle per memory wait state.
- Requesters must hold req and their operands stable until ack. A request dropped before its grant is ignored. Dropping after grant is illegal and unchecked.
- mem_ack while mem_req=0: ignored.
- i_rdata and d_rdata hold their last value between acks.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A wait counter clears on grant and increments each busy cycle without mem_ack.
  - On reaching MAX_WAIT: drop mem_req; pulse the owner's ack with rdata=ERR_DATA; pulse bus_err; go to IDLE with normal grant rules.
  - A mem_ack arriving in the same cycle as the timeout wins: normal completion, no bus_err.
- MEM_ARB_TIMEOUT_EN not defined: the arbiter waits indefinitely, bus_err is constant 0, and there is no counter logic.

Decomposition:
- Shared package holds:
  - the arb_state_t enum (IDLE, I_BUSY, D_BUSY);
  - the default ERR_DATA constant;
  - the MEM_ADDR_ALIGN_MASK constant.
- No sub-module. The FSM, grant logic and timeout counter are each small and are kept inline.

Test Plan:
- i_req=1, i_addr=0x100, memory acks on the first mem_req cycle with 0x6000_0000 -> mem_req at t+1, i_ack at t+2, i_rdata=0x6000_0000, state IDLE at t+3.
- i_req and d_req (load, 0x204) both asserted in the same cycle from reset -> D granted first (mem_addr=0x204, mem_we=0); stall=1 until d_ack; I granted back-to-back on the mem_ack cycle.
- Store d_addr=0x303, d_wdata=0xCAFE_F00D, memory with 3 wait states -> mem_addr=0x300, mem_we=1, bus outputs stable for 4 cycles, d_ack 5 cycles after d_req; d_rdata unchanged.
- d_req continuously re-issued while i_req is held -> grants alternate D, I, D, I; i_ack is never delayed by more than one data access.
- rst pulsed low mid D_BUSY -> mem_req, d_ack, stall-related outputs and state clear immediately (asynchronously); a later mem_ack is ignored; a re-issued d_req completes normally.
- With MEM_ARB_TIMEOUT_EN, MAX_WAIT=4, memory never acks an I read -> after 4 busy cycles mem_req=0, i_ack=1, i_rdata=0xDEAD_BEEF, bus_err pulses once; without the macro, mem_req stays high indefinitely.
